flush_pipe: RTL and testbench
=============================

Name: flush_pipe

Overview:
- Parametrised elastic pipeline: DEPTH register stages of WIDTH-bit data, each with its own valid bit, and valid/ready handshakes at both ends.
- A synchronous flush clears only the stages selected by FLUSH_MASK and loads FLUSH_VALUE into their data registers. Unselected stages keep moving as if no flush occurred.
- Sits between a producer and a consumer in datapaths that need selective squash, e.g. branch kill that spares committed stages.
- Also reports stage occupancy and counts entries discarded by flushes.

Parameters:
- WIDTH, 8, data width in bits (>=1)
- DEPTH, 3, number of stages (>=1); stage 0 is the input side, stage DEPTH-1 drives the output
- FLUSH_MASK, all ones (DEPTH bits), bit i = 1: stage i is cleared by flush; bit i = 0: stage i ignores flush
- FLUSH_VALUE, 0 (WIDTH bits), data loaded into flushed stages
- CNT_WIDTH, 8, width of drop_count

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- flush  in  1  synchronous flush request, acts in the cycle it is high
- in_valid  in  1  producer has data
- in_ready  out  1  pipeline accepts data this cycle
- in_data  in  WIDTH  producer data
- out_valid  out  1  stage DEPTH-1 holds data
- out_ready  in  1  consumer accepts data
- out_data  out  WIDTH  data register of stage DEPTH-1
- occupancy  out  clog2(DEPTH+1)  number of valid stages (registered state)
- drop_count  out  CNT_WIDTH  saturating count of valid entries discarded by flush

Behaviour:
- Reset (async, while rst=1):
  - all valid bits = 0 and all data registers = 0 (not FLUSH_VALUE)
  - drop_count = 0
  - so out_valid = 0, out_data = 0, occupancy = 0
  - rst mid-transfer discards everything; there is no partial state.
- Ready chain, no flush:
  - ready_i = ~valid_i | ready_(i+1); ready_DEPTH = out_ready.
  - in_ready = ready_0, combinational.
  - Stage i loads stage i-1 (or in_data for i=0) when ready_i = 1.
  - Its valid becomes the upstream valid qualified by the handshake.
- Latency and throughput:
  - in_data accepted at edge k appears on out_data after edge k+DEPTH-1, i.e. DEPTH cycles to output.
  - Full throughput: 1 item per cycle when out_ready is held 1.
- Stall: out_ready = 0 holds full stages in place. Bubbles collapse: an empty stage accepts even when everything downstream is stalled.
- Flush cycle (flush = 1), for each stage i:
  - FLUSH_MASK[i] = 1:
    - next valid_i = 0, next data_i = FLUSH_VALUE
    - the stage neither emits to i+1 nor accepts from i-1; its content is discarded
  - FLUSH_MASK[i] = 0: normal rules, except a flushed upstream provides nothing, so stage i can only drain.
  - If FLUSH_MASK[0] = 1: in_ready is forced 0.
  - If FLUSH_MASK[DEPTH-1] = 1: out_valid is forced 0 in the flush cycle, so no output handshake occurs.
  - out_valid = valid_(DEPTH-1) & ~(flush & FLUSH_MASK[DEPTH-1]).
- drop_count:
  - adds, each flush cycle, the number of stages with valid_i = 1 & FLUSH_MASK[i] = 1
  - saturates at 2^CNT_WIDTH-1
  - cleared only by rst
- Flush held for several cycles: flushed stages stay empty; unflushed stages downstream drain normally.
- Simultaneous rst and flush: rst wins.
- Cleared registers: a flushed stage's data register holds FLUSH_VALUE until overwritten. The same applies to out_data when the last stage is flushed.

Test Plan:
- DEPTH=3, WIDTH=8, out_ready=1: drive 0x11, 0x22, 0x33 back-to-back -> out_data 0x11, 0x22, 0x33 on cycles 3, 4, 5 with out_valid=1; occupancy peaks at 3.
- Fill 3 stages, out_ready=0 for 4 cycles -> in_ready=0 and out_data held at the first item; release -> items leave in order, none lost.
- FLUSH_MASK=3'b111, FLUSH_VALUE=0xA5, 3 valid entries, flush for 1 cycle -> next cycle occupancy=0, out_valid=0, out_data=0xA5, drop_count=3.
- FLUSH_MASK=3'b011 (stage 2 skipped), entries 0x01/0x02/0x03 in stages 0/1/2, out_ready=1, flush -> 0x03 is emitted in the flush cycle; afterwards all stages are empty and drop_count=2.
- drop_count saturation with CNT_WIDTH=2: flush a full 3-stage pipe twice -> drop_count=3, not wrapped.
- Assert rst mid-stream with flush=1 -> all outputs 0 asynchronously; after release, in_ready=1 and drop_count=0.

Source files
------------

// File: rtl/flush_pipe.sv
// flush_pipe: elastic DEPTH-stage valid/ready pipeline with selective flush.
// Ports: clk, rst (async, active-high), flush, in_valid/in_ready/in_data,
//        out_valid/out_ready/out_data, occupancy, drop_count.
module flush_pipe #(
    parameter int                 WIDTH       = 8,
    parameter int                 DEPTH       = 3,
    parameter logic [DEPTH-1:0]   FLUSH_MASK  = {DEPTH{1'b1}},
    parameter logic [WIDTH-1:0]   FLUSH_VALUE = '0,
    parameter int                 CNT_WIDTH   = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_data,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy,
    output logic [CNT_WIDTH-1:0]         drop_count
);

    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam int SUM_W = ((CNT_WIDTH > OCC_W) ? CNT_WIDTH : OCC_W) + 1;

    logic [DEPTH-1:0] valid_q;
    logic [WIDTH-1:0] data_q [DEPTH];

    logic [DEPTH-1:0] kill;
    logic [DEPTH:0]   ready;
    logic [DEPTH-1:0] up_valid;
    logic [WIDTH-1:0] up_data [DEPTH];
    logic [OCC_W-1:0] occ;
    logic [OCC_W-1:0] kill_cnt;
    logic [SUM_W-1:0] drop_sum;
    logic [SUM_W-1:0] cnt_max;
    logic [CNT_WIDTH-1:0] drop_next;

    // Ready chain runs from the consumer back to the producer; a killed
    // stage refuses input, and a killed upstream offers nothing.
    always_comb begin
        kill       = flush ? FLUSH_MASK : '0;
        ready      = '0;
        up_valid   = '0;
        ready[DEPTH] = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            ready[i] = ~kill[i] & (~valid_q[i] | ready[i+1]);
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (i == 0) begin
                up_valid[i] = in_valid;
                up_data[i]  = in_data;
            end else begin
                up_valid[i] = valid_q[i-1] & ~kill[i-1];
                up_data[i]  = data_q[i-1];
            end
        end
    end

    always_comb begin
        occ      = '0;
        kill_cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occ      = occ + OCC_W'(valid_q[i]);
            kill_cnt = kill_cnt + OCC_W'(valid_q[i] & kill[i]);
        end
        cnt_max  = SUM_W'({CNT_WIDTH{1'b1}});
        drop_sum = SUM_W'(drop_count) + SUM_W'(kill_cnt);
        if (drop_sum > cnt_max) begin
            drop_next = {CNT_WIDTH{1'b1}};
        end else begin
            drop_next = drop_sum[CNT_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q    <= '0;
            drop_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (kill[i]) begin
                    valid_q[i] <= 1'b0;
                    data_q[i]  <= FLUSH_VALUE;
                end else if (ready[i]) begin
                    valid_q[i] <= up_valid[i];
                    // Empty slots keep their old data so a cleared
                    // register shows FLUSH_VALUE until overwritten.
                    if (up_valid[i]) begin
                        data_q[i] <= up_data[i];
                    end
                end
            end
            if (flush) begin
                drop_count <= drop_next;
            end
        end
    end

    assign in_ready  = ready[0];
    assign out_valid = valid_q[DEPTH-1] & ~kill[DEPTH-1];
    assign out_data  = data_q[DEPTH-1];
    assign occupancy = occ;

endmodule

// File: tb/tb_flush_pipe.sv
// tb_flush_pipe: table-driven checks of flush_pipe plus a partial-mask
// flush sequence on a second instance.
module tb_flush_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic       in_valid;
    logic [7:0] in_data;
    logic       out_ready;

    logic       a_in_ready, a_out_valid;
    logic [7:0] a_out_data;
    logic [1:0] a_occ;
    logic [1:0] a_drop;

    logic       b_in_ready, b_out_valid;
    logic [7:0] b_out_data;
    logic [1:0] b_occ;
    logic [7:0] b_drop;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    flush_pipe #(
        .WIDTH(8), .DEPTH(3), .FLUSH_MASK(3'b111),
        .FLUSH_VALUE(8'hA5), .CNT_WIDTH(2)
    ) u_a (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
        .out_valid(a_out_valid), .out_ready(out_ready),
        .out_data(a_out_data), .occupancy(a_occ), .drop_count(a_drop)
    );

    flush_pipe #(
        .WIDTH(8), .DEPTH(3), .FLUSH_MASK(3'b011),
        .FLUSH_VALUE(8'h00), .CNT_WIDTH(8)
    ) u_b (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data),
        .out_valid(b_out_valid), .out_ready(out_ready),
        .out_data(b_out_data), .occupancy(b_occ), .drop_count(b_drop)
    );

    typedef struct {
        logic       rst;
        logic       flush;
        logic       iv;
        logic [7:0] id;
        logic       ordy;
        logic       eir;
        logic       eov;
        logic [7:0] eod;
        logic [1:0] eocc;
        logic [1:0] edrop;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(
        logic r, logic f, logic iv, logic [7:0] id, logic ordy,
        logic eir, logic eov, logic [7:0] eod,
        logic [1:0] eocc, logic [1:0] edrop);
        vec_t v;
        v.rst = r; v.flush = f; v.iv = iv; v.id = id; v.ordy = ordy;
        v.eir = eir; v.eov = eov; v.eod = eod;
        v.eocc = eocc; v.edrop = edrop;
        return v;
    endfunction

    task automatic check(string name, int row, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row=%0d got=%0h expected=%0h",
                     name, row, act, exp);
        end
    endtask

    task automatic drive(logic r, logic f, logic iv, logic [7:0] id,
                         logic ordy);
        @(negedge clk);
        rst = r; flush = f; in_valid = iv; in_data = id;
        out_ready = ordy;
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0;
        in_data = '0; out_ready = 1'b1;

        //         rst f  iv  id     or  ir ov od     occ drop
        vt.push_back(mk(1, 0, 0, 8'h00, 1, 1, 0, 8'h00, 0, 0));
        // back-to-back stream, out_ready held high
        vt.push_back(mk(0, 0, 1, 8'h11, 1, 1, 0, 8'h00, 0, 0));
        vt.push_back(mk(0, 0, 1, 8'h22, 1, 1, 0, 8'h00, 1, 0));
        vt.push_back(mk(0, 0, 1, 8'h33, 1, 1, 0, 8'h00, 2, 0));
        vt.push_back(mk(0, 0, 0, 8'h00, 1, 1, 1, 8'h11, 3, 0));
        vt.push_back(mk(0, 0, 0, 8'h00, 1, 1, 1, 8'h22, 2, 0));
        vt.push_back(mk(0, 0, 0, 8'h00, 1, 1, 1, 8'h33, 1, 0));
        vt.push_back(mk(0, 0, 0, 8'h00, 1, 1, 0, 8'h33, 0, 0));
        // fill with consumer stalled, bubbles collapse
        vt.push_back(mk(0, 0, 1, 8'h44, 0, 1, 0, 8'h33, 0, 0));
        vt.push_back(mk(0, 0, 1, 8'h55, 0, 1, 0, 8'h33, 1, 0));
        vt.push_back(mk(0, 0, 1, 8'h66, 0, 1, 0, 8'h33, 2, 0));
        // four stall cycles, full
        vt.push_back(mk(0, 0, 1, 8'h77, 0, 0, 1, 8'h44, 3, 0));
        vt.push_back(mk(0, 0, 1, 8'h77, 0, 0, 1, 8'h44, 3, 0));
        vt.push_back(mk(0, 0, 1, 8'h77, 0, 0, 1, 8'h44, 3, 0));
        vt.push_back(mk(0, 0, 1, 8'h77, 0, 0, 1, 8'h44, 3, 0));
        // release, items leave in order
        vt.push_back(mk(0, 0, 0, 8'h00, 1, 1, 1, 8'h44, 3, 0));
        vt.push_back(mk(0, 0, 1, 8'h88, 0, 1, 1, 8'h55, 2, 0));
        // full flush
        vt.push_back(mk(0, 1, 0, 8'h00, 1, 0, 0, 8'h55, 3, 0));
        vt.push_back(mk(0, 0, 0, 8'h00, 1, 1, 0, 8'hA5, 0, 3));
        // refill then flush again: counter saturates
        vt.push_back(mk(0, 0, 1, 8'h01, 0, 1, 0, 8'hA5, 0, 3));
        vt.push_back(mk(0, 0, 1, 8'h02, 0, 1, 0, 8'hA5, 1, 3));
        vt.push_back(mk(0, 0, 1, 8'h03, 0, 1, 0, 8'hA5, 2, 3));
        vt.push_back(mk(0, 1, 0, 8'h00, 0, 0, 0, 8'h01, 3, 3));
        vt.push_back(mk(0, 0, 0, 8'h00, 1, 1, 0, 8'hA5, 0, 3));
        vt.push_back(mk(0, 0, 1, 8'h09, 0, 1, 0, 8'hA5, 0, 3));
        // async reset with flush high, checked before any edge
        vt.push_back(mk(1, 1, 1, 8'h0F, 0, 0, 0, 8'h00, 0, 0));
        vt.push_back(mk(0, 0, 0, 8'h00, 1, 1, 0, 8'h00, 0, 0));

        for (int i = 0; i < vt.size(); i++) begin
            drive(vt[i].rst, vt[i].flush, vt[i].iv, vt[i].id, vt[i].ordy);
            check("in_ready",   i, int'(a_in_ready),  int'(vt[i].eir));
            check("out_valid",  i, int'(a_out_valid), int'(vt[i].eov));
            check("out_data",   i, int'(a_out_data),  int'(vt[i].eod));
            check("occupancy",  i, int'(a_occ),       int'(vt[i].eocc));
            check("drop_count", i, int'(a_drop),      int'(vt[i].edrop));
        end

        // Partial mask: stage 2 survives the flush and drains.
        drive(1, 0, 0, 8'h00, 0);
        drive(0, 0, 1, 8'h03, 0);
        drive(0, 0, 1, 8'h02, 0);
        drive(0, 0, 1, 8'h01, 0);
        drive(0, 1, 0, 8'h00, 1);
        check("pm_occ",       100, int'(b_occ),       3);
        check("pm_in_ready",  100, int'(b_in_ready),  0);
        check("pm_out_valid", 100, int'(b_out_valid), 1);
        check("pm_out_data",  100, int'(b_out_data),  8'h03);
        drive(0, 0, 0, 8'h00, 1);
        check("pm_occ",       101, int'(b_occ),       0);
        check("pm_out_valid", 101, int'(b_out_valid), 0);
        check("pm_in_ready",  101, int'(b_in_ready),  1);
        check("pm_drop",      101, int'(b_drop),      2);

        // Flush held two cycles on a lone stage-1 entry: it is dropped
        // once and the pipe stays empty.
        drive(0, 0, 1, 8'h0A, 0);
        drive(0, 0, 0, 8'h00, 0);
        drive(0, 1, 1, 8'h0B, 0);
        check("hold_occ",     102, int'(b_occ),       1);
        drive(0, 1, 1, 8'h0C, 0);
        check("hold_occ",     103, int'(b_occ),       0);
        check("hold_ready",   103, int'(b_in_ready),  0);
        drive(0, 0, 0, 8'h00, 1);
        check("hold_drop",    104, int'(b_drop),      3);
        check("hold_valid",   104, int'(b_out_valid), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
